// File: rtl/dram_axi_arbiter.sv
// Two-requester round-robin arbiter onto one AXI4-Lite-style DRAM port, one transaction in flight.
// Define ARB_FIXED_PRIO_EN for fixed priority (req0 always wins contention) instead of round-robin.
module dram_axi_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,
  output logic              ar_valid,
  output logic [ADDR_W-1:0] ar_addr,
  input  logic              ar_ready,
  input  logic              r_valid,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  output logic              r_ready,
  output logic              aw_valid,
  output logic [ADDR_W-1:0] aw_addr,
  input  logic              aw_ready,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  input  logic              w_ready,
  input  logic              b_valid,
  input  logic [1:0]        b_resp,
  output logic              b_ready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RESP} arbState;

  arbState           state;
  logic              curId;
  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curWdata;
  logic [DATA_W-1:0] rspData;
  logic              rspErr;
  logic              grant;
  logic              accept;

`ifndef ARB_FIXED_PRIO_EN
  logic              lastGrant;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    grant = !req0_valid;
`else
    if (req0_valid && req1_valid) grant = !lastGrant;
    else                          grant = !req0_valid;
`endif
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign ar_addr     = curAddr;
  assign aw_addr     = curAddr;
  assign w_data      = curWdata;
  assign resp0_rdata = rspData;
  assign resp1_rdata = rspData;
  assign resp0_err   = rspErr;
  assign resp1_err   = rspErr;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too because they drive ports that must read 0 in reset.
      state       <= IDLE;
      curId       <= 1'b0;
      curAddr     <= '0;
      curWdata    <= '0;
      rspData     <= '0;
      rspErr      <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      ar_valid    <= 1'b0;
      r_ready     <= 1'b0;
      aw_valid    <= 1'b0;
      w_valid     <= 1'b0;
      b_ready     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      lastGrant   <= 1'b1;
`endif
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          curId    <= grant;
          curAddr  <= grant ? req1_addr  : req0_addr;
          curWdata <= grant ? req1_wdata : req0_wdata;
`ifndef ARB_FIXED_PRIO_EN
          lastGrant <= grant;
`endif
          if (grant ? req1_write : req0_write) begin
            state    <= AW;
            aw_valid <= 1'b1;
          end else begin
            state    <= AR;
            ar_valid <= 1'b1;
          end
        end
        AR: if (ar_ready) begin
          ar_valid <= 1'b0;
          r_ready  <= 1'b1;
          state    <= R;
        end
        R: if (r_valid) begin
          r_ready     <= 1'b0;
          rspData     <= r_data;
          rspErr      <= (r_resp != 2'b00);
          resp0_valid <= !curId;
          resp1_valid <= curId;
          state       <= RESP;
        end
        // Address and data phases never overlap: W only starts once AW has handshaken.
        AW: if (aw_ready) begin
          aw_valid <= 1'b0;
          w_valid  <= 1'b1;
          state    <= W;
        end
        W: if (w_ready) begin
          w_valid <= 1'b0;
          b_ready <= 1'b1;
          state   <= B;
        end
        B: if (b_valid) begin
          b_ready     <= 1'b0;
          rspData     <= '0;
          rspErr      <= (b_resp != 2'b00);
          resp0_valid <= !curId;
          resp1_valid <= curId;
          state       <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_axi_arbiter.sv
// Randomized scoreboard bench for dram_axi_arbiter: DRAM slave model, request driver, response monitor.
module tb_dram_axi_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              req0_valid, req0_write, req0_ready, resp0_valid, resp0_err;
  logic              req1_valid, req1_write, req1_ready, resp1_valid, resp1_err;
  logic [ADDR_W-1:0] req0_addr, req1_addr, ar_addr, aw_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata, resp0_rdata, resp1_rdata, r_data, w_data;
  logic              ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready;
  logic              w_valid, w_ready, b_valid, b_ready;
  logic [1:0]        r_resp, b_resp;

  dram_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
    .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Shared environment rules: default DRAM contents and which addresses answer with SLVERR.
  function automatic logic [63:0] memInit(input logic [16:0] a);
    return {a, 15'h0, ~a, 15'h5A5};
  endfunction
  function automatic logic [1:0] errRule(input logic [16:0] a);
    return (a[5:3] == 3'b111) ? 2'd2 : 2'd0;
  endfunction

  logic [63:0] slvMem [int];
  logic [63:0] refMem [int];

  // ---------------- reference model / scoreboard state ----------------
  typedef struct { int id; logic [63:0] data; logic err; } expT;
  expT sbQ[$];
  int  mLast = 1;
  int  acceptedCnt = 0, respCnt = 0, acceptCyc = 0, respCyc = 0;
  int  respIdCnt [2] = '{0, 0};
  int  grantLog[$];
  logic [16:0] curAddr;
  logic [63:0] curData;

  bit          active [2] = '{0, 0};
  logic        pW [2];
  logic [16:0] pA [2];
  logic [63:0] pD [2];
  int          genProb = 0;
  bit          contention = 0;

  // ---------------- DRAM slave model ----------------
  int arDly = 0, rDly = 0, awDly = 0, wDly = 0, bDly = 0;
  int arCnt, rCnt, awCnt, wCnt, bCnt;
  bit arSeen = 0, rSeen = 0, awSeen = 0, wSeen = 0, bSeen = 0;
  bit rPend = 0, wPend = 0, bPend = 0;
  int arVCyc = 0, rRCyc = 0, lastArVCyc = 0, lastRRCyc = 0;
  logic [16:0] rAddr, wAddr, lastArAddr;
  logic [63:0] lastWData;

  function automatic int pick(input int d);
    return (d < 0) ? int'($urandom_range(0, 3)) : d;
  endfunction

  initial begin
    ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
    r_data = '0; r_resp = '0; b_resp = '0;
    forever begin
      @(negedge clk);
      ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
      r_data = '0; r_resp = '0; b_resp = '0;
      if (!rst_n) begin
        arSeen = 0; rSeen = 0; awSeen = 0; wSeen = 0; bSeen = 0;
        rPend = 0; wPend = 0; bPend = 0;
      end else begin
        check("axi valid overlap", (ar_valid && (aw_valid || w_valid)) || (aw_valid && w_valid), 1'b0);
        if (ar_valid) begin
          if (!arSeen) begin arSeen = 1; arCnt = pick(arDly); arVCyc = 0; end
          arVCyc++;
          if (arCnt == 0) begin
            ar_ready = 1; arSeen = 0; lastArVCyc = arVCyc;
            check("ar_addr", ar_addr, curAddr);
            lastArAddr = ar_addr; rAddr = ar_addr; rPend = 1;
          end else arCnt--;
        end
        if (r_ready && rPend) begin
          if (!rSeen) begin rSeen = 1; rCnt = pick(rDly); rRCyc = 0; end
          rRCyc++;
          if (rCnt == 0) begin
            r_valid = 1; r_data = slvMem.exists(int'(rAddr)) ? slvMem[int'(rAddr)] : memInit(rAddr);
            r_resp = errRule(rAddr); rPend = 0; rSeen = 0; lastRRCyc = rRCyc;
          end else rCnt--;
        end
        if (aw_valid) begin
          if (!awSeen) begin awSeen = 1; awCnt = pick(awDly); end
          if (awCnt == 0) begin
            aw_ready = 1; awSeen = 0;
            check("aw_addr", aw_addr, curAddr);
            wAddr = aw_addr; wPend = 1;
          end else awCnt--;
        end
        if (w_valid && wPend) begin
          if (!wSeen) begin wSeen = 1; wCnt = pick(wDly); end
          if (wCnt == 0) begin
            w_ready = 1; wSeen = 0; wPend = 0; bPend = 1;
            check("w_data", w_data, curData);
            lastWData = w_data; slvMem[int'(wAddr)] = w_data;
          end else wCnt--;
        end
        if (b_ready && bPend) begin
          if (!bSeen) begin bSeen = 1; bCnt = pick(bDly); end
          if (bCnt == 0) begin
            b_valid = 1; b_resp = errRule(wAddr); bPend = 0; bSeen = 0;
          end else bCnt--;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    expT e;
    int  id;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && (resp0_valid || resp1_valid)) begin
        check("resp exclusive", resp0_valid && resp1_valid, 1'b0);
        id = resp1_valid ? 1 : 0;
        if (sbQ.size() == 0) failNow("unexpected resp pulse");
        else begin
          e = sbQ.pop_front();
          check("resp id", id, e.id);
          check("resp rdata", id ? resp1_rdata : resp0_rdata, e.data);
          check("resp err", id ? resp1_err : resp0_err, e.err);
        end
        respCnt++;
        respCyc = cyc;
        respIdCnt[id]++;
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic applyPins();
    req0_valid = active[0]; req0_write = pW[0]; req0_addr = pA[0]; req0_wdata = pD[0];
    req1_valid = active[1]; req1_write = pW[1]; req1_addr = pA[1]; req1_wdata = pD[1];
  endtask

  task automatic issue(input int id, input logic w, input logic [16:0] a, input logic [63:0] d);
    active[id] = 1; pW[id] = w; pA[id] = a; pD[id] = d;
    applyPins();
  endtask

  function automatic logic [63:0] refRead(input logic [16:0] a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : memInit(a);
  endfunction

  task automatic acceptReq(input int id);
    expT e;
    e.id   = id;
    e.err  = (errRule(pA[id]) != 2'd0);
    e.data = pW[id] ? 64'h0 : refRead(pA[id]);
    if (pW[id]) refMem[int'(pA[id])] = pD[id];
    sbQ.push_back(e);
    mLast = id;
    acceptedCnt++;
    acceptCyc = cyc;
    curAddr = pA[id];
    curData = pD[id];
    grantLog.push_back(id);
    active[id] = 0;
  endtask

  task automatic cycle();
    bit busy;
    int g;
    @(negedge clk);
    busy = (acceptedCnt != respCnt);
    g = -1;
    if (rst_n && !busy && (active[0] || active[1])) begin
`ifdef ARB_FIXED_PRIO_EN
      g = active[0] ? 0 : 1;
`else
      g = (active[0] && active[1]) ? 1 - mLast : (active[0] ? 0 : 1);
`endif
    end
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    if (req0_ready && active[0])      acceptReq(0);
    else if (req1_ready && active[1]) acceptReq(1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!active[i] && (contention || ($urandom_range(0, 99) < genProb))) begin
        active[i] = 1;
        pW[i] = 1'($urandom_range(0, 1));
        pA[i] = 17'($urandom_range(0, 31) << 3);
        pD[i] = {$urandom, $urandom};
      end
    end
    applyPins();
  endtask

  task automatic runUntilIdle(input int maxC, input string name);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((active[0] || active[1] || acceptedCnt != respCnt) && n < maxC);
    if (active[0] || active[1] || acceptedCnt != respCnt) failNow(name);
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, " ar_valid"}, ar_valid, 1'b0);
    check({tag, " aw_valid"}, aw_valid, 1'b0);
    check({tag, " w_valid"}, w_valid, 1'b0);
    check({tag, " r_ready"}, r_ready, 1'b0);
    check({tag, " b_ready"}, b_ready, 1'b0);
    check({tag, " resp valids"}, {resp0_valid, resp1_valid}, 2'b00);
    check({tag, " req readys"}, {req0_ready, req1_ready}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r0, r1;
    int n;
    pW = '{0, 0}; pA = '{0, 0}; pD = '{0, 0};
    applyPins();
    rst_n = 0;
    #1;
    checkIdleOutputs("reset");
    check("reset ar_addr", ar_addr, 17'h0);
    check("reset w_data", w_data, 64'h0);
    check("reset resp0_rdata", resp0_rdata, 64'h0);
    check("reset resp err", {resp0_err, resp1_err}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single read, zero-wait DRAM.
    refMem[32'h10000] = 64'h0123_4567_89AB_CDEF;
    slvMem[32'h10000] = 64'h0123_4567_89AB_CDEF;
    r0 = respIdCnt[0]; r1 = respIdCnt[1];
    issue(0, 1'b0, 17'h10000, 64'h0);
    runUntilIdle(50, "single read timeout");
    check("read ar_addr", lastArAddr, 17'h10000);
    check("read latency", respCyc - acceptCyc, 3);
    check("read resp0 pulses", respIdCnt[0] - r0, 1);
    check("read resp1 pulses", respIdCnt[1] - r1, 0);
    check("read data held", resp0_rdata, 64'h0123_4567_89AB_CDEF);

    // Single write.
    r0 = respIdCnt[0]; r1 = respIdCnt[1];
    issue(1, 1'b1, 17'h10008, 64'hFFFF_0000_FFFF_0000);
    runUntilIdle(50, "single write timeout");
    check("write w_data", lastWData, 64'hFFFF_0000_FFFF_0000);
    check("write latency", respCyc - acceptCyc, 4);
    check("write resp1 pulses", respIdCnt[1] - r1, 1);
    check("write resp0 pulses", respIdCnt[0] - r0, 0);
    check("write err", resp1_err, 1'b0);

    // Error response then a clean read.
    issue(0, 1'b1, 17'h00038, 64'hDEAD_BEEF_0000_1111);
    runUntilIdle(50, "error write timeout");
    check("bresp err flag", resp0_err, 1'b1);
    issue(1, 1'b0, 17'h00040, 64'h0);
    runUntilIdle(50, "post-error read timeout");
    check("err cleared on ok read", resp1_err, 1'b0);

    // Wait states on AR and R.
    arDly = 5; rDly = 7;
    r0 = respIdCnt[0]; r1 = respIdCnt[1];
    issue(1, 1'b0, 17'h00050, 64'h0);
    runUntilIdle(100, "wait-state read timeout");
    check("ar_valid high cycles", lastArVCyc, 6);
    check("r_ready high cycles", lastRRCyc, 8);
    check("wait-state resp pulses", (respIdCnt[0] - r0) + (respIdCnt[1] - r1), 1);
    arDly = -1; rDly = -1; awDly = -1; wDly = -1; bDly = -1;

    // Random traffic with random DRAM wait states.
    genProb = 40;
    repeat (800) cycle();
    genProb = 0;
    runUntilIdle(400, "random drain timeout");

    // Reset while the write data phase is stalled.
    arDly = 0; rDly = 0; awDly = 0; wDly = 10; bDly = 0;
    issue(1, 1'b1, 17'h10100, 64'hCAFE_F00D_1234_5678);
    n = 0;
    do begin cycle(); n++; end while (!w_valid && n < 20);
    if (!w_valid) failNow("w_valid never reached before reset");
    rst_n = 0;
    active = '{0, 0};
    applyPins();
    sbQ.delete();
    acceptedCnt = respCnt;
    mLast = 1;
    #1;
    checkIdleOutputs("abort");
    repeat (3) begin
      @(negedge clk);
      check("no resp in reset", {resp0_valid, resp1_valid}, 2'b00);
    end
    @(posedge clk);
    #1 rst_n = 1;
    wDly = 0;

    // Contention: both requesters held valid for four grants.
    grantLog.delete();
    contention = 1;
    issue(0, 1'b0, 17'h00008, 64'h0);
    issue(1, 1'b0, 17'h00010, 64'h0);
    n = 0;
    while (grantLog.size() < 4 && n < 100) begin cycle(); n++; end
    contention = 0;
    if (grantLog.size() < 4) failNow("contention grants timeout");
    else begin
`ifdef ARB_FIXED_PRIO_EN
      check("contention order", {grantLog[0][1:0], grantLog[1][1:0], grantLog[2][1:0], grantLog[3][1:0]}, 8'b00_00_00_00);
`else
      check("contention order", {grantLog[0][1:0], grantLog[1][1:0], grantLog[2][1:0], grantLog[3][1:0]}, 8'b00_01_00_01);
`endif
    end
    runUntilIdle(200, "contention drain timeout");
    repeat (3) cycle();
    check("scoreboard empty", sbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_axi_arbiter.md
Name: dram_axi_arbiter

Overview:
- Shares the single AXI4-Lite-style DRAM port (pseudo_DRAM side of the interface) between two internal requesters of the Program datapath: req0 = fetch unit, req1 = write-back unit.
- Sequences each transfer through its AR/R or AW/W/B handshakes, with one outstanding transaction at a time.
- Arbitrates round-robin and returns read data or an error flag to the winning requester.

Parameters:
- ADDR_W, 17, DRAM byte address width.
- DATA_W, 64, DRAM data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  request pending (N = 0, 1; one set per requester).
- reqN_write  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_W  target address.
- reqN_wdata  in  DATA_W  write data (ignored on reads).
- reqN_ready  out  1  request accepted this cycle.
- respN_valid  out  1  one-cycle completion pulse.
- respN_rdata  out  DATA_W  read data, valid with respN_valid.
- respN_err  out  1  nonzero r_resp/b_resp, valid with respN_valid.
- ar_valid  out  1  read address valid.
- ar_addr  out  ADDR_W  read address.
- ar_ready  in  1  read address ready.
- r_valid  in  1  read data valid.
- r_data  in  DATA_W  read data.
- r_resp  in  2  read response.
- r_ready  out  1  read data ready.
- aw_valid  out  1  write address valid.
- aw_addr  out  ADDR_W  write address.
- aw_ready  in  1  write address ready.
- w_valid  out  1  write data valid.
- w_data  out  DATA_W  write data.
- w_ready  in  1  write data ready.
- b_valid  in  1  write response valid.
- b_resp  in  2  write response.
- b_ready  out  1  write response ready.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs 0; state IDLE; last_grant = 1, so req0 wins the first contention.
  - Asserting rst_n mid-transaction aborts immediately: all valid/ready outputs drop, and no resp pulse is issued.
- States: IDLE, AR, R, AW, W, B, RESP.
- IDLE:
  - reqN_ready is combinational and asserts only for the granted requester.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one != last_grant.
  - On reqN_valid && reqN_ready: latch id, write, addr and wdata; update last_grant. Next state is AW if write, else AR.
- AR: ar_valid = 1 with the latched addr. On ar_ready go to R; ar_valid is 0 in the following cycle.
- R: r_ready = 1. On r_valid, latch r_data and err = (r_resp != 0), then go to RESP.
- AW: aw_valid = 1. On aw_ready go to W.
  - AW and W are strictly sequential; w_valid is never asserted together with aw_valid.
- W: w_valid = 1 with the latched wdata. On w_ready go to B.
- B: b_ready = 1. On b_valid, set err = (b_resp != 0), rdata = 0, go to RESP.
- RESP:
  - respN_valid = 1 for exactly one cycle, only for the latched id.
  - respN_rdata/respN_err are held until the next RESP.
  - Next state is IDLE. A new grant is possible in the cycle after RESP, so the minimum turnaround is 1 idle cycle.
- Outputs: all AXI valid/ready outputs are registered from state; no combinational path from AXI inputs to AXI outputs.
- Latency: minimum read, accept to resp pulse, is 3 cycles (AR, R, RESP) with a zero-wait DRAM. Minimum write is 4 cycles (AW, W, B, RESP).
- Request inputs are ignored outside IDLE. Requesters must hold valid and payload until ready.
- Simultaneous reqN_valid with the same address: no hazard checking; requests are serviced in grant order.
- A requester deasserting valid before ready is a protocol error and is not required to be handled.

Optional Feature:
- ARB_FIXED_PRIO_EN
  - Defined: fixed priority, req0 always wins contention; last_grant is unused.
  - Undefined (default): round-robin as specified above.

Test Plan:
- Single read: req0 read addr 0x10000, DRAM returns 0x0123_4567_89AB_CDEF with r_resp = 0 → ar_addr = 0x10000; resp0_valid pulses once with that data and err = 0; resp1_valid stays 0.
- Single write: req1 write addr 0x10008, wdata 0xFFFF_0000_FFFF_0000 → AW handshake precedes W with no overlap; w_data matches; resp1_valid pulses with err = 0.
- Contention: req0 and req1 both valid in the same cycle after reset, held for 4 transactions → grant order 0, 1, 0, 1. With ARB_FIXED_PRIO_EN defined the order is 0, 0, 0, 0 while req0 stays valid.
- Wait states: ar_ready delayed 5 cycles and r_valid delayed 7 cycles → ar_valid stays high for 6 cycles, r_ready stays high until r_valid, and exactly one resp pulse is issued.
- Error response: write with b_resp = 2 → respN_err = 1 with respN_valid; the next read with r_resp = 0 reports err = 0.
- Reset mid-op: drop rst_n in state W → w_valid = 0 immediately and no resp pulse. After release, the first contention grants req0.
